// File: rtl/pla_sweep_pkg.sv
// Shared types and helpers for the PLA vector sweeper: FSM states, the default
// MISR polynomial and the single-step MISR update used by pla_misr.
package pla_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sweep_state_e;

    localparam logic [15:0] DEFAULT_POLY = 16'h1021;

    // Widest signature misr_next can handle; narrower MISRs are zero-extended.
    localparam int MISR_MAX_W = 64;

    function automatic logic [MISR_MAX_W-1:0] misr_next(
        input logic [MISR_MAX_W-1:0] sig,
        input logic                  bit_in,
        input logic [MISR_MAX_W-1:0] poly,
        input int unsigned           width
    );
        logic [MISR_MAX_W-1:0] mask;
        logic [MISR_MAX_W-1:0] nxt;
        mask = (width >= MISR_MAX_W) ? '1 : ((64'd1 << width) - 64'd1);
        nxt  = (sig << 1) ^ (sig[6'(width - 1)] ? poly : '0)
             ^ {{(MISR_MAX_W-1){1'b0}}, bit_in};
        return nxt & mask;
    endfunction

endpackage

// File: rtl/pla_vector_sweeper_if.sv
// Bus between the sweeper and the PLA under test / its controller.
// master = sweeper side, slave = environment side.
interface pla_vector_sweeper_if #(
    parameter int N_IN  = 8,
    parameter int SIG_W = 16
);
    logic              start;
    logic [N_IN-1:0]   x_out;
    logic              y_in;
    logic              busy;
    logic              done;
    logic [N_IN:0]     onset_count;
    logic [SIG_W-1:0]  signature;

    modport master (
        input  start, y_in,
        output x_out, busy, done, onset_count, signature
    );

    modport slave (
        output start, y_in,
        input  x_out, busy, done, onset_count, signature
    );
endinterface

// File: rtl/pla_misr.sv
// Serial-input MISR: one response bit is shifted in per enabled cycle.
// clear has priority over enable; the seed after clear or reset is zero.
module pla_misr
    import pla_sweep_pkg::*;
#(
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             enable,
    input  logic             bit_in,
    output logic [SIG_W-1:0] signature
);

    logic [SIG_W-1:0] sig_q;
    logic [SIG_W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = SIG_W'(misr_next(MISR_MAX_W'(sig_q), bit_in,
                                     MISR_MAX_W'(POLY), SIG_W));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign signature = sig_q;

endmodule

// File: rtl/pla_vector_sweeper.sv
// Exhaustive sweeper for an N_IN-input PLA: drives every vector, counts ones and
// compacts responses into a MISR. PLA_SWEEP_XOR_OFFSET_EN adds an XOR offset on x_out.
module pla_vector_sweeper
    import pla_sweep_pkg::*;
#(
    parameter int               N_IN  = 8,
    parameter int               PIPE  = 0,
    parameter int               SIG_W = 16,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef PLA_SWEEP_XOR_OFFSET_EN
    input  logic [N_IN-1:0]      offset,
`endif
    pla_vector_sweeper_if.master bus
);

    localparam logic [N_IN-1:0] LAST_VEC = '1;
    // Valid-pipe pattern seen on the edge that samples the final vector.
    localparam logic [PIPE:0]   LAST_PAT = (PIPE+1)'(1) << PIPE;

    sweep_state_e    state_q, state_d;
    logic [N_IN-1:0] counter_q, counter_d;
    logic [PIPE:0]   vld_q, vld_d;
    logic [N_IN:0]   onset_q, onset_d;
    logic            sample_en;
    logic            misr_clr;

    assign sample_en = vld_q[PIPE];

    // NOTE: every signal assigned in this block gets a default first, so no
    // path through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        onset_d   = onset_q;
        misr_clr  = 1'b0;

        if (sample_en) begin
            onset_d = onset_q + (N_IN+1)'(bus.y_in);
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d   = SWEEP;
                    counter_d = '0;
                    onset_d   = '0;
                    misr_clr  = 1'b1;
                end
            end
            SWEEP: begin
                if (counter_q == LAST_VEC) begin
                    state_d = (PIPE == 0) ? DONE : DRAIN;
                end else begin
                    counter_d = counter_q + 1'b1;
                end
            end
            DRAIN: begin
                if (vld_q == LAST_PAT) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Bit 0 marks a cycle in which a vector is on x_out; it ages by one per edge.
        vld_d = (vld_q << 1) | (PIPE+1)'(state_d == SWEEP);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            counter_q <= '0;
            vld_q     <= '0;
            onset_q   <= '0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            vld_q     <= vld_d;
            onset_q   <= onset_d;
        end
    end

`ifdef PLA_SWEEP_XOR_OFFSET_EN
    logic [N_IN-1:0] offset_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            offset_q <= '0;
        end else if (misr_clr) begin
            offset_q <= offset;
        end
    end

    assign bus.x_out = counter_q ^ offset_q;
`else
    assign bus.x_out = counter_q;
`endif

    pla_misr #(
        .SIG_W (SIG_W),
        .POLY  (POLY)
    ) u_misr (
        .clk       (clk),
        .rst       (rst),
        .clear     (misr_clr),
        .enable    (sample_en),
        .bit_in    (bus.y_in),
        .signature (bus.signature)
    );

    assign bus.busy        = (state_q == SWEEP) || (state_q == DRAIN);
    assign bus.done        = (state_q == DONE);
    assign bus.onset_count = onset_q;

endmodule
